// File: rtl/qsys_m1_arbiter.sv
// Two-requester arbiter sharing one Avalon-MM master: alternating priority on
// contention, one command per grant, and an in-order read-ID FIFO for steering returns.
module qsys_m1_arbiter #(
  parameter int MAX_RD = 4
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [31:0] avs_S0_address,
  input  logic [31:0] avs_S0_writedata,
  input  logic [3:0]  avs_S0_byteenable,
  input  logic        avs_S0_read,
  input  logic        avs_S0_write,
  output logic [31:0] avs_S0_readdata,
  output logic        avs_S0_readdatavalid,
  output logic        avs_S0_waitrequest,
  input  logic [31:0] avs_S1_address,
  input  logic [31:0] avs_S1_writedata,
  input  logic [3:0]  avs_S1_byteenable,
  input  logic        avs_S1_read,
  input  logic        avs_S1_write,
  output logic [31:0] avs_S1_readdata,
  output logic        avs_S1_readdatavalid,
  output logic        avs_S1_waitrequest,
  output logic [31:0] avm_M1_address,
  output logic [31:0] avm_M1_writedata,
  output logic [3:0]  avm_M1_byteenable,
  output logic        avm_M1_read,
  output logic        avm_M1_write,
  input  logic [31:0] avm_M1_readdata,
  input  logic        avm_M1_readdatavalid,
  input  logic        avm_M1_waitrequest,
  output logic        coe_ERR_orphan
);

  localparam int PW = $clog2(MAX_RD);
  localparam int CW = PW + 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_gnt, w_gnt_nxt;
  logic              r_last, w_last_nxt;
  logic [MAX_RD-1:0] r_fifo;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_orphan;

  logic w_req0, w_req1, w_busy, w_sel_rd, w_sel_wr, w_full;
  logic w_accept, w_push, w_pop, w_head, w_gnt_wait;

  assign w_req0   = avs_S0_read | avs_S0_write;
  assign w_req1   = avs_S1_read | avs_S1_write;
  assign w_busy   = (r_state == ST_BUSY);
  assign w_sel_rd = r_gnt ? avs_S1_read  : avs_S0_read;
  assign w_sel_wr = r_gnt ? avs_S1_write : avs_S0_write;
  assign w_full   = (r_count == CW'(MAX_RD));

  assign avm_M1_address    = r_gnt ? avs_S1_address    : avs_S0_address;
  assign avm_M1_writedata  = r_gnt ? avs_S1_writedata  : avs_S0_writedata;
  assign avm_M1_byteenable = r_gnt ? avs_S1_byteenable : avs_S0_byteenable;
  // Reads are held off while every read ID slot is in use; writes still pass.
  assign avm_M1_read       = w_busy & w_sel_rd & ~w_full;
  assign avm_M1_write      = w_busy & w_sel_wr;

  assign w_accept   = (avm_M1_read | avm_M1_write) & ~avm_M1_waitrequest;
  assign w_push     = w_accept & avm_M1_read;
  assign w_pop      = avm_M1_readdatavalid & (r_count != '0);
  assign w_head     = r_fifo[r_rptr];
  assign w_gnt_wait = avm_M1_waitrequest | (w_full & w_sel_rd & ~w_sel_wr);

  assign avs_S0_waitrequest   = w_busy ? (r_gnt  | w_gnt_wait) : w_req0;
  assign avs_S1_waitrequest   = w_busy ? (~r_gnt | w_gnt_wait) : w_req1;
  assign avs_S0_readdatavalid = w_pop & ~w_head;
  assign avs_S1_readdatavalid = w_pop & w_head;
  assign avs_S0_readdata      = avm_M1_readdata;
  assign avs_S1_readdata      = avm_M1_readdata;
  assign coe_ERR_orphan       = r_orphan;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 | w_req1) begin
          w_state_nxt = ST_BUSY;
          w_gnt_nxt   = (w_req0 & w_req1) ? ~r_last : w_req1;
        end
      end
      ST_BUSY: begin
        if (w_accept) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_gnt;
        end else if (!(w_sel_rd | w_sel_wr)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // ID storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge csi_MCLK_clk) begin
    if (w_push) r_fifo[r_wptr] <= r_gnt;
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (avm_M1_readdatavalid && (r_count == '0)) r_orphan <= 1'b1;
    end
  end

endmodule

// File: doc/qsys_m1_arbiter.md
QSYS_M1_ARBITER -- requirements
Module: qsys_m1_arbiter

Interface
REQ-001 SHALL have parameter MAX_RD, default 4, meaning maximum outstanding reads (power of 2, 2..16).
REQ-002 SHALL have ports, clock and reset first:
- csi_MCLK_clk  in  1  sole clock.
- rsi_MRST_reset_n  in  1  reset, asynchronous, active-low.
- avs_S0_address / avs_S0_writedata  in  32 / 32  requester 0 (host bridge) command.
- avs_S0_byteenable  in  4  requester 0 byte enables.
- avs_S0_read / avs_S0_write  in  1 / 1  requester 0 strobes.
- avs_S0_readdata  out  32  requester 0 read data.
- avs_S0_readdatavalid / avs_S0_waitrequest  out  1 / 1  requester 0 handshake.
- avs_S1_*  same set and widths  requester 1 (local DMA).
- avm_M1_address / avm_M1_writedata / avm_M1_byteenable  out  32 / 32 / 4  shared master command.
- avm_M1_read / avm_M1_write  out  1 / 1  shared master strobes.
- avm_M1_readdata  in  32  shared read data.
- avm_M1_readdatavalid / avm_M1_waitrequest  in  1 / 1  shared handshake.
- coe_ERR_orphan  out  1  sticky: readdatavalid arrived with no outstanding read.

Function
REQ-003 SHALL implement two states: IDLE, BUSY; registered grant bit gnt and last-served bit last.
REQ-004 IDLE: request r_i = read_i | write_i; if exactly one r_i, gnt <= i; if both, gnt <= ~last; any request -> BUSY next cycle; no request -> stay IDLE.
REQ-005 IDLE: both avs waitrequest = 1 whenever corresponding r_i = 1; avm read/write = 0.
REQ-006 BUSY: avm address/writedata/byteenable/read/write = granted requester's inputs combinationally; non-granted requester waitrequest = 1.
REQ-007 BUSY: granted waitrequest = avm_M1_waitrequest, except forced 1 under REQ-010.
REQ-008 BUSY: command accepted when (avm read|write) & !avm_M1_waitrequest; on accept last <= gnt, state -> IDLE; exactly one command per grant.
REQ-009 BUSY: if granted requester drops read and write without acceptance, state -> IDLE, last unchanged.
REQ-010 Read-ID FIFO of depth MAX_RD, 1-bit entries (requester index), count register; accepted read pushes gnt; if count == MAX_RD, avm_M1_read forced 0 and granted waitrequest forced 1 until a pop occurs (writes unaffected).
REQ-011 avm_M1_readdatavalid with count > 0 pops head; head index h gets avs_Sh_readdatavalid = 1 same cycle; other requester 0.
REQ-012 avs_S0_readdata and avs_S1_readdata SHALL both equal avm_M1_readdata (zero-latency pass-through).
REQ-013 Simultaneous push and pop: count unchanged, pointers both advance; push at count == MAX_RD blocked even with same-cycle pop.
REQ-014 readdatavalid with count == 0: no pop, no requester readdatavalid, coe_ERR_orphan <= 1 until reset.
REQ-015 Pointers wrap modulo MAX_RD; count width clog2(MAX_RD)+1.
REQ-016 Minimum arbitration overhead one cycle: request seen in IDLE cycle N, command visible on avm at N+1.

Reset
REQ-017 Reset assertion SHALL immediately force: state IDLE, gnt 0, last 1, FIFO pointers and count 0, coe_ERR_orphan 0, avm read/write 0, all avs readdatavalid 0.
REQ-018 Reset mid-transaction SHALL discard outstanding read IDs; returning readdatavalid after reset sets coe_ERR_orphan.
REQ-019 Deassertion SHALL be synchronized to csi_MCLK_clk rising edge; first arbitration on first cycle after release.

Verification
REQ-020 S0 and S1 read simultaneously, slave waitrequest 0 -> S0 granted first (last=1 after reset), S1 next; addresses appear on avm at cycles 1 and 3.
REQ-021 S1 writes 0xA5A5A5A5 to 0x1000, slave waitrequest held 3 cycles -> avm_M1_write high 4 cycles, S1 waitrequest high until accept, S0 waitrequest 1 throughout.
REQ-022 Five S0 reads with readdatavalid withheld, MAX_RD=4 -> four accepted, fifth stalls with avm_M1_read 0; one readdatavalid -> fifth issued.
REQ-023 Interleaved S0,S1,S0 reads outstanding, data 0x11,0x22,0x33 returned in order -> delivered to S0,S1,S0 respectively.
REQ-024 readdatavalid pulse with no outstanding read -> coe_ERR_orphan 1 and stays 1; reset clears to 0.
REQ-025 Reset asserted in BUSY with 2 reads outstanding -> all outputs per REQ-017 within same cycle; subsequent read completes normally.
